slab_compare_sequencer: RTL

- Computes the ray/AABB slab-test verdict from six precomputed slab distances (near/far per axis) in FloPoCo 11_3 format.
- Computes tmin = max(near_x,near_y,near_z) and tmax = min(far_x,far_y,far_z), then hit = (tmin < tmax) and tmax non-negative.
- Time-shares one external pipelined less-than comparator (FPSub-based, registered less flag) across five dependent compares, issuing independent compares back-to-back.

---
 rtl/slab_compare_sequencer_if.sv | 16 +
 rtl/slab_compare_sequencer.sv | 114 +++++++++++
 2 files changed

// File: rtl/slab_compare_sequencer_if.sv
// slab_compare_sequencer_if: request/result handshake plus the shared-comparator port of the slab sequencer
interface slab_compare_sequencer_if #(parameter int WIDTH = 16);
   logic           start, ready, busy, done, hit;
   logic [WIDTH:0] near_x, near_y, near_z, far_x, far_y, far_z;
   logic [WIDTH:0] t_min, t_max;
   logic [WIDTH:0] cmp_a, cmp_b;
   logic           cmp_issue, cmp_less;
   modport master (
      output start, near_x, near_y, near_z, far_x, far_y, far_z, cmp_less,
      input  ready, busy, done, hit, t_min, t_max, cmp_a, cmp_b, cmp_issue
   );
   modport slave (
      input  start, near_x, near_y, near_z, far_x, far_y, far_z, cmp_less,
      output ready, busy, done, hit, t_min, t_max, cmp_a, cmp_b, cmp_issue
   );
endinterface

// File: rtl/slab_compare_sequencer.sv
// slab_compare_sequencer: ray/AABB slab verdict from five compares time-shared on one pipelined comparator
module slab_compare_sequencer #(
   parameter int WIDTH   = 16,
   parameter int CMP_LAT = 3
) (
   input logic                     clk,
   input logic                     rst,
   slab_compare_sequencer_if.slave bus
);
   typedef enum logic [3:0] {
      S_IDLE, S_ISS1, S_ISS3, S_WAIT_A, S_ISS2, S_ISS4, S_WAIT_B, S_ISS5, S_WAIT_C, S_DONE
   } state_t;
   state_t         r_state, w_next;
   logic [3:0]     r_cnt;
   logic [2:0]     r_tag [CMP_LAT];
   logic [2:0]     w_step, w_tag;
   logic [WIDTH:0] r_nx, r_ny, r_nz, r_fx, r_fy, r_fz, r_m, r_f, r_tmin, r_tmax;
   logic [WIDTH:0] r_cmp_a, r_cmp_b, r_t_min, r_t_max, w_op_a, w_op_b, w_sel4;
   logic           r_hit, w_wait, w_last, w_load;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_wait ? r_cnt + 4'd1 : 4'd0;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = bus.start ? S_ISS1 : S_IDLE;
         S_ISS1:   w_next = S_ISS3;
         S_ISS3:   w_next = S_WAIT_A;
         S_WAIT_A: w_next = w_last ? S_ISS2 : S_WAIT_A;
         S_ISS2:   w_next = S_ISS4;
         S_ISS4:   w_next = S_WAIT_B;
         S_WAIT_B: w_next = w_last ? S_ISS5 : S_WAIT_B;
         S_ISS5:   w_next = S_WAIT_C;
         S_WAIT_C: w_next = w_last ? S_DONE : S_WAIT_C;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_wait = r_state inside {S_WAIT_A, S_WAIT_B, S_WAIT_C};
      w_last = r_cnt == 4'(CMP_LAT - 1);
      w_step = r_state == S_ISS1 ? 3'd1 :
               r_state == S_ISS3 ? 3'd3 :
               r_state == S_ISS2 ? 3'd2 :
               r_state == S_ISS4 ? 3'd4 :
               r_state == S_ISS5 ? 3'd5 : 3'd0;
      w_tag  = r_tag[CMP_LAT-1];
      w_sel4 = bus.cmp_less ? r_f : r_fz;
      w_load = w_next inside {S_ISS1, S_ISS3, S_ISS2, S_ISS4, S_ISS5};
      // step5 issues on the same edge step4 lands, so its tmax operand is forwarded
      w_op_a = w_next == S_ISS1 ? bus.near_x :
               w_next == S_ISS3 ? r_fx :
               w_next == S_ISS2 ? r_m :
               w_next == S_ISS4 ? r_f : r_tmin;
      w_op_b = w_next == S_ISS1 ? bus.near_y :
               w_next == S_ISS3 ? r_fy :
               w_next == S_ISS2 ? r_nz :
               w_next == S_ISS4 ? r_fz : w_sel4;
   end

   assign bus.ready     = r_state == S_IDLE;
   assign bus.busy      = r_state != S_IDLE;
   assign bus.done      = r_state == S_DONE;
   assign bus.cmp_issue = w_step != 3'd0;
   assign bus.cmp_a     = r_cmp_a;
   assign bus.cmp_b     = r_cmp_b;
   assign bus.hit       = r_hit;
   assign bus.t_min     = r_t_min;
   assign bus.t_max     = r_t_max;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CMP_LAT; i++) r_tag[i] <= '0;
      end else begin
         r_tag[0] <= w_step;
         for (int i = 1; i < CMP_LAT; i++) r_tag[i] <= r_tag[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         {r_nx, r_ny, r_nz, r_fx, r_fy, r_fz} <= '0;
         {r_m, r_f, r_tmin, r_tmax}           <= '0;
         {r_cmp_a, r_cmp_b, r_t_min, r_t_max} <= '0;
         r_hit <= 1'b0;
      end else begin
         if (r_state == S_IDLE && bus.start) begin
            {r_nx, r_ny, r_nz} <= {bus.near_x, bus.near_y, bus.near_z};
            {r_fx, r_fy, r_fz} <= {bus.far_x, bus.far_y, bus.far_z};
         end
         if (w_load) begin
            r_cmp_a <= w_op_a;
            r_cmp_b <= w_op_b;
         end
         if (w_tag == 3'd1) r_m    <= bus.cmp_less ? r_ny : r_nx;
         if (w_tag == 3'd3) r_f    <= bus.cmp_less ? r_fx : r_fy;
         if (w_tag == 3'd2) r_tmin <= bus.cmp_less ? r_nz : r_m;
         if (w_tag == 3'd4) r_tmax <= w_sel4;
         if (w_tag == 3'd5) begin
            r_hit   <= bus.cmp_less & ~r_tmax[WIDTH-2];
            r_t_min <= r_tmin;
            r_t_max <= r_tmax;
         end
      end
   end
endmodule
